// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the MEM-stage load/store unit.
// Holds the funct3 access-size codes, the FSM state codes and a small address helper.
package mem_access_unit_pkg;

    // funct3 access-size encodings (loads use all five, stores use B/H/W only)
    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    // FSM state codes
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // Word-aligned form of a byte address, as presented on the bus
    function automatic logic [31:0] word_addr(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_access_unit_store_align.sv
// Combinational lane aligner: from access size and byte offset, produces the
// byte enables, lane-replicated store data and a misalignment flag.
// Used for loads too, where only the misalignment flag matters.
module mem_access_unit_store_align
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  byte_off,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] lane_data,
    output logic        misaligned
);

    logic [31:0] byte_rep;
    logic [31:0] half_rep;

    // Replicate the low byte into all four lanes and the low half into both halves
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_byte_rep
            assign byte_rep[gi*8 +: 8] = wdata[7:0];
        end
        for (genvar gi = 0; gi < 2; gi++) begin : g_half_rep
            assign half_rep[gi*16 +: 16] = wdata[15:0];
        end
    endgenerate

    // Decode size into enables, lane data and alignment; unknown sizes behave as word
    always_comb begin
        be         = 4'b1111;
        lane_data  = wdata;
        misaligned = 1'b0;
        case (size)
            MEM_B, MEM_BU: begin
                be        = 4'b0001 << byte_off;
                lane_data = byte_rep;
            end
            MEM_H, MEM_HU: begin
                be         = byte_off[1] ? 4'b1100 : 4'b0011;
                lane_data  = half_rep;
                misaligned = byte_off[0];
            end
            default: begin
                misaligned = (byte_off != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: converts EX/MEM load/store requests into a
// word-aligned bus transaction, stalls until acknowledge or timeout, and
// registers the raw read word plus byte offset for the WB-stage extender.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_rd_i,
    input  logic        mem_wr_i,
    input  logic [2:0]  mem_size_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic        stall_o,
    output logic [31:0] ld_data_o,
    output logic [1:0]  ld_byte_sel_o,
    output logic        ld_valid_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [0:0]       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [1:0]       byte_off_reg;
    logic             bus_req_reg;
    logic             bus_we_reg;
    logic [31:0]      bus_addr_reg;
    logic [3:0]       bus_be_reg;
    logic [31:0]      bus_wdata_reg;
    logic [31:0]      ld_data_reg;
    logic [1:0]       ld_byte_sel_reg;
    logic             ld_valid_reg;
    logic             misalign_reg;
    logic             bus_err_reg;

    logic [3:0]       align_be;
    logic [31:0]      align_data;
    logic             align_mis;
    logic             req_any;
    logic             start;
    logic             timeout_hit;

    mem_access_unit_store_align u_align (
        .size       (mem_size_i),
        .byte_off   (addr_i[1:0]),
        .wdata      (wdata_i),
        .be         (align_be),
        .lane_data  (align_data),
        .misaligned (align_mis)
    );

    // Request qualification and timeout detection for the current cycle
    always_comb begin
        req_any     = mem_rd_i | mem_wr_i;
        start       = (state_reg == ST_IDLE) & req_any & ~align_mis;
        timeout_hit = TO_EN & (state_reg == ST_WAIT) & ~bus_ack_i & (cnt_reg == TO_LAST);
    end

    // Stall while an access is pending; release in the cycle it completes
    // (ack or abort) so the pipeline advances together with the capture.
    // Held low during reset so a frozen upstream request cannot keep it high.
    always_comb begin
        stall_o = 1'b0;
        if (rst_n) begin
            if (state_reg == ST_IDLE)
                stall_o = start;
            else
                stall_o = ~bus_ack_i & ~timeout_hit;
        end
    end

    // Access FSM, bus output registers and load capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            byte_off_reg    <= 2'b00;
            bus_req_reg     <= 1'b0;
            bus_we_reg      <= 1'b0;
            bus_addr_reg    <= 32'h0;
            bus_be_reg      <= 4'h0;
            bus_wdata_reg   <= 32'h0;
            ld_data_reg     <= 32'h0;
            ld_byte_sel_reg <= 2'b00;
            ld_valid_reg    <= 1'b0;
            misalign_reg    <= 1'b0;
            bus_err_reg     <= 1'b0;
        end else begin
            ld_valid_reg <= 1'b0;
            misalign_reg <= 1'b0;
            bus_err_reg  <= 1'b0;
            if (state_reg == ST_IDLE) begin
                misalign_reg <= req_any & align_mis;
                if (start) begin
                    state_reg     <= ST_WAIT;
                    cnt_reg       <= '0;
                    bus_req_reg   <= 1'b1;
                    bus_we_reg    <= mem_wr_i;
                    bus_addr_reg  <= word_addr(addr_i);
                    bus_be_reg    <= mem_wr_i ? align_be : 4'b1111;
                    bus_wdata_reg <= align_data;
                    byte_off_reg  <= addr_i[1:0];
                end
            end else begin
                if (bus_ack_i) begin
                    // Ack wins over a coincident timeout
                    state_reg   <= ST_IDLE;
                    bus_req_reg <= 1'b0;
                    if (!bus_we_reg) begin
                        ld_data_reg     <= bus_rdata_i;
                        ld_byte_sel_reg <= byte_off_reg;
                        ld_valid_reg    <= 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_reg   <= ST_IDLE;
                    bus_req_reg <= 1'b0;
                    bus_err_reg <= 1'b1;
                    if (!bus_we_reg) begin
                        ld_data_reg     <= 32'h0;
                        ld_byte_sel_reg <= byte_off_reg;
                        ld_valid_reg    <= 1'b1;
                    end
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    end

    assign bus_req_o     = bus_req_reg;
    assign bus_we_o      = bus_we_reg;
    assign bus_addr_o    = bus_addr_reg;
    assign bus_be_o      = bus_be_reg;
    assign bus_wdata_o   = bus_wdata_reg;
    assign ld_data_o     = ld_data_reg;
    assign ld_byte_sel_o = ld_byte_sel_reg;
    assign ld_valid_o    = ld_valid_reg;
    assign misalign_o    = misalign_reg;
    assign bus_err_o     = bus_err_reg;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage load/store unit for the RISC-V pipeline. It sits between the EX/MEM pipeline register and the data-memory bus.
- Turns load/store requests into a word-aligned bus transaction with byte enables and replicated store data.
- Stalls the pipeline until the bus acknowledges.
- Registers the raw read word and byte offset for the WB-stage load extender.
- Flags misaligned accesses and bus timeouts.

Parameters:
TIMEOUT_CYCLES, 255, cycles in WAIT without bus_ack before the access is aborted; 0 disables the timeout.
CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
mem_rd_i  in  1  load request from EX/MEM.
mem_wr_i  in  1  store request from EX/MEM; mem_rd_i and mem_wr_i are never both 1.
mem_size_i  in  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores use 000/001/010 only).
addr_i  in  32  byte address.
wdata_i  in  32  store data, right-justified.
bus_req_o  out  1  bus request.
bus_we_o  out  1  1 = write.
bus_addr_o  out  32  {addr_i[31:2], 2'b00}.
bus_be_o  out  4  byte enables.
bus_wdata_o  out  32  lane-replicated store data.
bus_ack_i  in  1  one-cycle transaction acknowledge.
bus_rdata_i  in  32  read word, valid with bus_ack_i.
stall_o  out  1  freeze the upstream pipeline.
ld_data_o  out  32  registered raw read word for WB.
ld_byte_sel_o  out  2  registered addr[1:0] for WB.
ld_valid_o  out  1  one-cycle pulse: ld_data_o is new.
misalign_o  out  1  one-cycle pulse: misaligned access rejected.
bus_err_o  out  1  one-cycle pulse: timeout abort.

Behaviour:
- Reset (asynchronous, active-low):
  - State goes to IDLE and the timeout counter clears.
  - All outputs go to 0, except bus_addr_o, bus_be_o and bus_wdata_o, which are don't-care while bus_req_o=0 but are also reset to 0.
  - Asserting rst_n low mid-transaction drops bus_req_o immediately. A late bus_ack_i arriving after release is ignored.
- Misalignment check:
  - H/HU/SH with addr[0]=1 is misaligned.
  - W/SW with addr[1:0]!=0 is misaligned.
  - A misaligned access issues no bus request and raises no stall. misalign_o pulses on the next edge.
- FSM states: IDLE, WAIT.
- IDLE:
  - start = (mem_rd_i | mem_wr_i) & aligned.
  - stall_o = start (combinational).
  - On start, the next edge latches the address, byte enables, data and write flag into output registers, sets bus_req_o=1, clears the counter and moves to WAIT.
- WAIT:
  - stall_o=1. bus_req and the address/data/enable registers are held stable.
  - When bus_ack_i=1:
    - bus_req_o drops on the next edge and state returns to IDLE.
    - For a read, ld_data_o<=bus_rdata_i, ld_byte_sel_o<=latched addr[1:0], and ld_valid_o pulses for 1 cycle.
    - stall_o is 0 in the ack cycle, so the pipeline advances together with the capture.
  - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES-1 and bus_ack_i is 0 (TIMEOUT_CYCLES!=0):
    - bus_req_o drops, bus_err_o pulses and state returns to IDLE.
    - For a read, ld_data_o<=0 and ld_valid_o pulses.
  - If ack and timeout coincide, ack wins.
- Back-to-back accesses: a new request presented in the first IDLE cycle after ack is accepted. Minimum spacing is therefore 2 cycles per access with zero-wait-state memory.
- Byte enables and store data:
  - SB: be = 4'b0001 << addr[1:0], wdata = {4{wdata_i[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{wdata_i[15:0]}}.
  - SW: be = 4'b1111, wdata = wdata_i.
  - Loads: be = 4'b1111, bus_we_o=0.
- ld_data_o and ld_byte_sel_o hold their values between ld_valid_o pulses.

Decomposition:
- Add MEM_B/H/W/BU/HU funct3 encodings and the FSM state codes to Parameters.v, next to the existing load-type constants.
- One sub-module, store_align: combinational (size, addr[1:0], wdata) -> (be, lane data, misaligned). It is reused for both the load and store checks.

Test Plan:
1. SW addr=0x100, wdata=0xDEADBEEF, ack after 2 WAIT cycles -> bus_addr=0x100, be=1111, we=1; stall high for 3 cycles; no ld_valid.
2. LB addr=0x203, bus_rdata=0x80FF1234 on a 0-wait ack -> ld_data_o=0x80FF1234, ld_byte_sel_o=3, ld_valid_o 1-cycle pulse; bus_addr=0x200.
3. SH addr=0x12, wdata=0x0000ABCD -> be=1100, bus_wdata=0xABCDABCD; SB addr=0x11, wdata=0x5A -> be=0010, wdata=0x5A5A5A5A.
4. LW addr=0x102 -> misalign_o pulse, bus_req_o stays 0, stall_o stays 0.
5. TIMEOUT_CYCLES=4, LW with ack never asserted -> bus_err_o pulse 4 cycles after entering WAIT, ld_data_o=0, FSM back in IDLE; a following LW completes normally.
6. rst_n pulled low in WAIT -> bus_req_o and stall_o go to 0 asynchronously; an ack after release produces no ld_valid_o.
